// File: rtl/dcache_ctrl.sv
// dcache_ctrl: one-at-a-time load/store sequencer for a write-back, write-allocate set-associative data cache.
// Define DCACHE_PERF_CNT_EN to add hit/miss counter outputs.
module dcache_ctrl #(
    parameter  int NUM_WAY        = 2,
    parameter  int BYTES_PER_LINE = 16,
    parameter  int NUM_LINE       = 256,
    localparam int WORDS_PER_LINE = BYTES_PER_LINE / 4,
    localparam int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
    localparam int INDEX_WIDTH    = $clog2(NUM_LINE),
    localparam int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH,
    localparam int BANK_NUM_WIDTH = $clog2(WORDS_PER_LINE),
    localparam int LINE_WIDTH     = BYTES_PER_LINE * 8,
    localparam int RR_WIDTH       = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_op,
    input  logic [31:0]               i_req_addr,
    input  logic [3:0]                i_req_wstrb,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_resp_valid,
    output logic [31:0]               o_resp_rdata,
    output logic                      o_rd_req,
    input  logic                      i_rd_ready,
    output logic [31:0]               o_rd_addr,
    input  logic                      i_ret_valid,
    input  logic                      i_ret_last,
    input  logic [31:0]               i_ret_data,
    output logic                      o_wr_req,
    input  logic                      i_wr_ready,
    output logic [31:0]               o_wr_addr,
    output logic [LINE_WIDTH-1:0]     o_wr_data,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]               o_hit_cnt,
    output logic [31:0]               o_miss_cnt,
`endif
    output logic [INDEX_WIDTH-1:0]    o_tbl_index,
    output logic [TAG_WIDTH-1:0]      o_tbl_tag,
    output logic [BANK_NUM_WIDTH-1:0] o_tbl_bank_num,
    output logic [NUM_WAY-1:0]        o_tbl_read_way,
    output logic [NUM_WAY-1:0]        o_tbl_d_way,
    output logic [INDEX_WIDTH-1:0]    o_tbl_d_index,
    input  logic [NUM_WAY-1:0]        i_tbl_hit_way,
    input  logic [NUM_WAY-1:0]        i_tbl_v_ways,
    input  logic [31:0]               i_tbl_rdata,
    input  logic [LINE_WIDTH-1:0]     i_tbl_read_line,
    input  logic [TAG_WIDTH-1:0]      i_tbl_read_tag,
    input  logic                      i_tbl_dirty,
    output logic                      o_tbl_write,
    output logic [NUM_WAY-1:0]        o_tbl_write_way,
    output logic [INDEX_WIDTH-1:0]    o_tbl_write_index,
    output logic [BANK_NUM_WIDTH-1:0] o_tbl_write_bank_num,
    output logic [31:0]               o_tbl_write_data,
    output logic [3:0]                o_tbl_write_strb,
    output logic [NUM_WAY-1:0]        o_tbl_d_write_way,
    output logic                      o_tbl_d_write,
    output logic [NUM_WAY-1:0]        o_tbl_tag_v_write_way,
    output logic [TAG_WIDTH-1:0]      o_tbl_tag_write,
    output logic                      o_tbl_v_write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_WB,
        S_RD_REQ,
        S_REFILL,
        S_RESP
    } state_t;

    state_t                    r_state;
    logic [31:0]               r_addr;
    logic                      r_op;
    logic [3:0]                r_wstrb;
    logic [31:0]               r_wdata;
    logic [NUM_WAY-1:0]        r_victim;
    logic                      r_victim_vld;
    logic [RR_WIDTH-1:0]       r_rr;
    logic [BANK_NUM_WIDTH-1:0] r_cnt;
    logic [31:0]               r_wb_addr;
    logic [LINE_WIDTH-1:0]     r_wb_line;
    logic [31:0]               r_resp_rdata;

    logic [INDEX_WIDTH-1:0]    w_index;
    logic [TAG_WIDTH-1:0]      w_tag;
    logic [BANK_NUM_WIDTH-1:0] w_bank;
    logic                      w_hit;
    logic [NUM_WAY-1:0]        w_victim;
    logic                      w_victim_vld;
    logic [31:0]               w_merge;
    logic                      w_unused_ok;

    assign w_index     = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_tag       = r_addr[31 -: TAG_WIDTH];
    assign w_bank      = r_addr[2 +: BANK_NUM_WIDTH];
    assign w_hit       = |i_tbl_hit_way;
    assign w_unused_ok = ^r_addr[1:0];

    // An empty way always beats the round-robin choice; lowest index wins.
    always_comb begin
        w_victim       = '0;
        w_victim[r_rr] = 1'b1;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            if (!i_tbl_v_ways[w]) begin
                w_victim    = '0;
                w_victim[w] = 1'b1;
            end
        end
        w_victim_vld = |(w_victim & i_tbl_v_ways);
    end

    // Store-miss data is folded into the refill beat of the requested word.
    always_comb begin
        w_merge = i_ret_data;
        if (r_op && (r_cnt == w_bank)) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    w_merge[8*b +: 8] = r_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_op         <= 1'b0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_victim     <= '0;
            r_victim_vld <= 1'b0;
            r_rr         <= '0;
            r_cnt        <= '0;
            r_wb_addr    <= '0;
            r_wb_line    <= '0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr  <= i_req_addr;
                        r_op    <= i_req_op;
                        r_wstrb <= i_req_wstrb;
                        r_wdata <= i_req_wdata;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (!r_op) begin
                            r_resp_rdata <= i_tbl_rdata;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_victim     <= w_victim;
                        r_victim_vld <= w_victim_vld;
                        r_state      <= S_MISS;
                    end
                end
                S_MISS: begin
                    r_wb_line <= i_tbl_read_line;
                    r_wb_addr <= {i_tbl_read_tag, w_index, {OFFSET_WIDTH{1'b0}}};
                    r_state   <= (r_victim_vld && i_tbl_dirty) ? S_WB : S_RD_REQ;
                end
                S_WB: begin
                    if (i_wr_ready) begin
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (i_rd_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (i_ret_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!r_op && (r_cnt == w_bank)) begin
                            r_resp_rdata <= i_ret_data;
                        end
                        // A short burst still closes the line and marks it valid.
                        if (i_ret_last) begin
                            r_rr    <= (r_rr == RR_WIDTH'(NUM_WAY - 1)) ? '0 : r_rr + 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_rd_req     = (r_state == S_RD_REQ);
    assign o_wr_req     = (r_state == S_WB);
    assign o_rd_addr    = {w_tag, w_index, {OFFSET_WIDTH{1'b0}}};
    assign o_wr_addr    = r_wb_addr;
    assign o_wr_data    = r_wb_line;
    assign o_resp_valid = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_RESP);
    assign o_resp_rdata = (r_state == S_LOOKUP) ? i_tbl_rdata : r_resp_rdata;

    // Array control; every write enable is suppressed while reset is asserted.
    always_comb begin
        o_tbl_index           = (r_state == S_IDLE) ? i_req_addr[OFFSET_WIDTH +: INDEX_WIDTH] : w_index;
        o_tbl_d_index         = o_tbl_index;
        o_tbl_tag             = w_tag;
        o_tbl_bank_num        = w_bank;
        o_tbl_read_way        = '0;
        o_tbl_d_way           = '0;
        o_tbl_write           = 1'b0;
        o_tbl_write_way       = '0;
        o_tbl_write_index     = w_index;
        o_tbl_write_bank_num  = w_bank;
        o_tbl_write_data      = r_wdata;
        o_tbl_write_strb      = r_wstrb;
        o_tbl_d_write_way     = '0;
        o_tbl_d_write         = 1'b0;
        o_tbl_tag_v_write_way = '0;
        o_tbl_tag_write       = w_tag;
        o_tbl_v_write         = 1'b0;
        if (!reset) begin
            case (r_state)
                S_LOOKUP: begin
                    if (w_hit && r_op) begin
                        o_tbl_write       = 1'b1;
                        o_tbl_write_way   = i_tbl_hit_way;
                        o_tbl_d_write_way = i_tbl_hit_way;
                        o_tbl_d_write     = 1'b1;
                    end
                end
                S_MISS: begin
                    o_tbl_read_way = r_victim;
                    o_tbl_d_way    = r_victim;
                end
                S_REFILL: begin
                    if (i_ret_valid) begin
                        o_tbl_write          = 1'b1;
                        o_tbl_write_way      = r_victim;
                        o_tbl_write_bank_num = r_cnt;
                        o_tbl_write_data     = w_merge;
                        o_tbl_write_strb     = 4'hF;
                        o_tbl_d_write_way    = r_victim;
                        o_tbl_d_write        = r_op;
                        if (i_ret_last) begin
                            o_tbl_tag_v_write_way = r_victim;
                            o_tbl_v_write         = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`else
    // Counters compiled out; no other logic depends on them.
`endif

endmodule
